instr_bus_demux: RTL and testbench



---
 rtl/instr_bus_demux_if.sv | 30 +++
 rtl/instr_bus_demux.sv | 140 ++++++++++++++
 tb/tb_instr_bus_demux.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_bus_demux_if.sv
// Ibex-style instruction fetch bus: request/grant address phase plus an
// rvalid response phase carrying read data and an error flag.
interface ibex_instr_bus;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Requester side (the core, or this demux facing a slave)
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  // Responder side (a memory, or this demux facing the core)
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/instr_bus_demux.sv
// Instruction bus demultiplexer: routes Ibex fetches to a boot ROM or a code
// RAM by address, answers unmapped fetches locally with an error, and keeps
// responses in order by only switching targets once the pipeline has drained.
module instr_bus_demux #(
  parameter logic [31:0] ROM_BASE        = 32'h0000_0000,
  parameter logic [31:0] ROM_MASK        = 32'hFFFF_F000,
  parameter logic [31:0] RAM_BASE        = 32'h0001_0000,
  parameter logic [31:0] RAM_MASK        = 32'hFFFF_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ibex_instr_bus.slave   core,
  ibex_instr_bus.master  rom,
  ibex_instr_bus.master  ram,
  output logic           resp_err
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_ROM  = 2'd1,
    TGT_RAM  = 2'd2,
    TGT_ERR  = 2'd3
  } tgt_e;

  tgt_e             dec_c;
  tgt_e             tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_c;
  logic             allowed_c;
  logic             gnt_c;
  logic             rvalid_c;
  logic             accept_c;
  logic             spurious_c;

  // Address decode; ROM takes priority where the two windows overlap
  always_comb begin
    dec_c = TGT_ERR;
    if ((core.addr & ROM_MASK) == ROM_BASE) begin
      dec_c = TGT_ROM;
    end else if ((core.addr & RAM_MASK) == RAM_BASE) begin
      dec_c = TGT_RAM;
    end
  end

  // Issue is allowed on an empty pipeline, or to the current target below the cap
  always_comb begin
    busy_c    = (cnt_q != '0);
    allowed_c = !busy_c ||
                ((tgt_q == dec_c) && (cnt_q < CNT_W'(MAX_OUTSTANDING)));
  end

  // Request path: steer req to the decoded slave and return its grant
  always_comb begin
    rom.req  = 1'b0;
    ram.req  = 1'b0;
    rom.addr = core.addr;
    ram.addr = core.addr;
    gnt_c    = 1'b0;
    if (rst_n && allowed_c) begin
      case (dec_c)
        TGT_ROM: begin
          rom.req = core.req;
          gnt_c   = rom.gnt;
        end
        TGT_RAM: begin
          ram.req = core.req;
          gnt_c   = ram.gnt;
        end
        TGT_ERR: gnt_c = 1'b1;
        default: gnt_c = 1'b0;
      endcase
    end
  end

  // Response path: forward only the slave that owns the outstanding fetches
  always_comb begin
    rvalid_c   = 1'b0;
    core.rdata = 32'h0;
    core.err   = 1'b0;
    if (busy_c) begin
      case (tgt_q)
        TGT_ROM: begin
          if (rom.rvalid) begin
            rvalid_c   = 1'b1;
            core.rdata = rom.rdata;
            core.err   = rom.err;
          end
        end
        TGT_RAM: begin
          if (ram.rvalid) begin
            rvalid_c   = 1'b1;
            core.rdata = ram.rdata;
            core.err   = ram.err;
          end
        end
        TGT_ERR: begin
          rvalid_c = 1'b1;
          core.err = 1'b1;
        end
        default: rvalid_c = 1'b0;
      endcase
    end
  end

  // Handshake qualifiers and detection of responses nobody is waiting for
  always_comb begin
    core.gnt    = gnt_c;
    core.rvalid = rvalid_c;
    accept_c    = core.req && gnt_c;
    spurious_c  = (rom.rvalid && !(busy_c && (tgt_q == TGT_ROM))) ||
                  (ram.rvalid && !(busy_c && (tgt_q == TGT_RAM)));
  end

  // Outstanding count, owning target and sticky unexpected-response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      tgt_q    <= TGT_NONE;
      resp_err <= 1'b0;
    end else begin
      if (accept_c && !rvalid_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (rvalid_c && !accept_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (accept_c) begin
        tgt_q <= dec_c;
      end else if (rvalid_c && (cnt_q == CNT_W'(1))) begin
        tgt_q <= TGT_NONE;
      end
      if (spurious_c) begin
        resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_bus_demux.sv
// Randomised bench for instr_bus_demux with a queue-based reference model:
// the model tracks the list of granted-but-unanswered fetches by target.
module tb_instr_bus_demux;

  localparam int MAXO = 2;
  localparam int T_ROM = 1;
  localparam int T_RAM = 2;
  localparam int T_ERR = 3;

  logic clk;
  logic rst_n;
  logic resp_err;

  ibex_instr_bus core_bus ();
  ibex_instr_bus rom_bus ();
  ibex_instr_bus ram_bus ();

  instr_bus_demux #(
    .ROM_BASE        (32'h0000_0000),
    .ROM_MASK        (32'hFFFF_F000),
    .RAM_BASE        (32'h0001_0000),
    .RAM_MASK        (32'hFFFF_0000),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (core_bus),
    .rom      (rom_bus),
    .ram      (ram_bus),
    .resp_err (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int q[$];
  bit m_resp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory map by plain address ranges: ROM [0,4K), RAM [64K,128K), else error
  function automatic int decode(input logic [31:0] a);
    if (a < 32'h0000_1000) return T_ROM;
    if (a >= 32'h0001_0000 && a < 32'h0002_0000) return T_RAM;
    return T_ERR;
  endfunction

  task automatic idle_inputs();
    core_bus.req    = 1'b0;
    core_bus.addr   = 32'h0;
    rom_bus.gnt     = 1'b0;
    ram_bus.gnt     = 1'b0;
    rom_bus.rvalid  = 1'b0;
    ram_bus.rvalid  = 1'b0;
    rom_bus.rdata   = 32'h0;
    ram_bus.rdata   = 32'h0;
    rom_bus.err     = 1'b0;
    ram_bus.err     = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model
  task automatic step(input logic req, input logic [31:0] addr,
                      input logic rg, input logic ag,
                      input logic rrv, input logic arv,
                      input logic [31:0] rdat, input logic [31:0] adat,
                      input logic rerr, input logic aerr);
    int d, front;
    bit allowed, e_gnt, e_rv, e_err, e_rreq, e_areq;
    logic [31:0] e_rdata;
    @(negedge clk);
    core_bus.req   = req;
    core_bus.addr  = addr;
    rom_bus.gnt    = rg;
    ram_bus.gnt    = ag;
    rom_bus.rvalid = rrv;
    ram_bus.rvalid = arv;
    rom_bus.rdata  = rdat;
    ram_bus.rdata  = adat;
    rom_bus.err    = rerr;
    ram_bus.err    = aerr;
    #1;
    d       = decode(addr);
    front   = (q.size() > 0) ? q[0] : 0;
    allowed = (q.size() == 0) || (front == d && q.size() < MAXO);
    e_gnt   = allowed && ((d == T_ROM) ? rg : (d == T_RAM) ? ag : 1'b1);
    e_rreq  = req && allowed && d == T_ROM;
    e_areq  = req && allowed && d == T_RAM;
    e_rv    = 1'b0;
    e_err   = 1'b0;
    e_rdata = 32'h0;
    if (front == T_ROM && rrv) begin e_rv = 1'b1; e_rdata = rdat; e_err = rerr; end
    if (front == T_RAM && arv) begin e_rv = 1'b1; e_rdata = adat; e_err = aerr; end
    if (front == T_ERR) begin e_rv = 1'b1; e_err = 1'b1; end
    check("core_gnt",   32'(core_bus.gnt),    32'(e_gnt));
    check("rom_req",    32'(rom_bus.req),     32'(e_rreq));
    check("ram_req",    32'(ram_bus.req),     32'(e_areq));
    check("rom_addr",   rom_bus.addr,         addr);
    check("ram_addr",   ram_bus.addr,         addr);
    check("core_rvalid",32'(core_bus.rvalid), 32'(e_rv));
    check("core_rdata", core_bus.rdata,       e_rdata);
    check("core_err",   32'(core_bus.err),    32'(e_err));
    check("resp_err",   32'(resp_err),        32'(m_resp_err));
    if ((rrv && front != T_ROM) || (arv && front != T_RAM)) m_resp_err = 1'b1;
    if (e_rv) void'(q.pop_front());
    if (req && e_gnt) q.push_back(d);
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Answer outstanding fetches from the owning slave until the model is empty
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'(q[0] == T_ROM), 1'(q[0] == T_RAM),
           32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i), 1'b0, 1'b0);
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  // Reset with busy-looking inputs: every output must read zero meanwhile
  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    core_bus.req   = 1'b1;
    core_bus.addr  = 32'h0000_0100;
    rom_bus.gnt    = 1'b1;
    ram_bus.gnt    = 1'b1;
    rom_bus.rvalid = 1'b1;
    ram_bus.rvalid = 1'b1;
    rom_bus.rdata  = 32'hDEAD_BEEF;
    ram_bus.rdata  = 32'hCAFE_F00D;
    rom_bus.err    = 1'b1;
    ram_bus.err    = 1'b1;
    #1;
    check("rst_gnt",      32'(core_bus.gnt),    32'd0);
    check("rst_rvalid",   32'(core_bus.rvalid), 32'd0);
    check("rst_err",      32'(core_bus.err),    32'd0);
    check("rst_rdata",    core_bus.rdata,       32'd0);
    check("rst_rom_req",  32'(rom_bus.req),     32'd0);
    check("rst_ram_req",  32'(ram_bus.req),     32'd0);
    check("rst_resp_err", 32'(resp_err),        32'd0);
    q.delete();
    m_resp_err = 1'b0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0FFC;
      1: return 32'h0000_1000;
      2: return 32'h0000_FFFC;
      3: return 32'h0001_0000;
      4: return 32'h0001_FFFC;
      5: return 32'h0002_0000;
      6: return 32'h8000_0000 | 32'($urandom_range(0, 255) << 2);
      7, 8: return 32'h0001_0000 | 32'($urandom_range(0, 16383) << 2);
      default: return 32'($urandom_range(0, 1023) << 2);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    do_reset();

    // ROM fetch with data on the following cycle
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    idle_step();

    // Two back-to-back RAM fetches, third stalls until a response arrives
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0004, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0008, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();

    // Target switch: RAM request waits behind an outstanding ROM fetch
    step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();

    // Unmapped fetch answered locally with an error
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle_step();
    idle_step();

    // Accept and response together on RAM, then a spurious ROM response
    step(1'b1, 32'h0001_0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0014, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h2222_0000, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3333_0000, 32'h0, 1'b0, 1'b0);
    idle_step();
    drain();

    // Reset with two RAM fetches outstanding, then a late RAM response
    do_reset();
    step(1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0001_0004, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4444_0000, 1'b0, 1'b0);
    idle_step();

    // Random traffic in several reset-separated chunks
    for (int c = 0; c < 4; c++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        int front;
        logic rrv, arv;
        front = (q.size() > 0) ? q[0] : 0;
        rrv = (front == T_ROM) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 99) == 0);
        arv = (front == T_RAM) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 99) == 0);
        step(1'($urandom_range(0, 3) != 0), rand_addr(),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             rrv, arv, $urandom, $urandom,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
